alu_inst_fetch: RTL and testbench

ALU_INST_FETCH -- requirements
Module: alu_inst_fetch

---
 rtl/alu_inst_fetch.sv | 160 ++++++++++++++++
 tb/tb_alu_inst_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : alu_inst_fetch
// Brief    : In-order instruction fetcher with a credit-limited issue queue
//            feeding a downstream ALU pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module alu_inst_fetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [7:0]        imem_rsp_data,
    output logic [7:0]        inst,
    output logic              inst_valid,
    output logic              busy,
    output logic              done,
    output logic              rsp_err
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issued_q;
    logic [CNT_W-1:0]  outst_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [7:0]        fifo_q [DEPTH];
    logic [7:0]        inst_q;
    logic              inst_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              rsp_err_q;

    logic w_hs;
    logic w_push;
    logic w_pop;

    // Credit: queued entries plus in-flight requests never exceed the queue size.
    assign imem_req_valid = (state_q == S_FETCH) && (pc_q < len_q)
                          && ((count_q + outst_q) < DEPTH_CNT);
    assign imem_req_addr  = pc_q;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign w_push         = imem_rsp_valid && (outst_q != '0);
    assign w_pop          = (count_q != '0);

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            outst_q      <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inst_q       <= 8'h00;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (w_hs) begin
                pc_q <= pc_q + 1'b1;
            end
            case ({w_hs, w_push})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: ;
            endcase
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                issued_q <= issued_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            inst_q       <= w_pop ? fifo_q[rd_ptr_q] : 8'h00;
            inst_valid_q <= w_pop;
            if (imem_rsp_valid && (outst_q == '0)) begin
                rsp_err_q <= 1'b1;
            end
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q     <= '0;
                        len_q    <= prog_len;
                        issued_q <= '0;
                        outst_q  <= '0;
                        count_q  <= '0;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        if (prog_len != '0) begin
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_hs && ((pc_q + 1'b1) == len_q)) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((issued_q == len_q) && (outst_q == '0)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_inst_fetch
// Brief    : Randomized self-checking bench for alu_inst_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_inst_fetch;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] prog_len;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [7:0]        imem_rsp_data;
    logic [7:0]        inst;
    logic              inst_valid;
    logic              busy;
    logic              done;
    logic              rsp_err;

    alu_inst_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .prog_len       (prog_len),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .busy           (busy),
        .done           (done),
        .rsp_err        (rsp_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] mem_img [256];
    logic [7:0] exp_q [$];
    int         pend_addr [$];
    int         pend_due [$];
    int         exp_pc, n_hs, n_issued, n_done;
    int         first_iss, last_iss, done_cyc, start_cyc;
    bit         exp_err, mon_en, post_rst;
    int         lat_min = 1;
    int         lat_max = 1;
    int         rdy_pct = 100;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: observe what the last edge produced, then drive the next one.
    task automatic cycle(input bit st, input logic [7:0] pl, input bit r, input bit spur);
        int lat;
        int due;
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (post_rst) begin
                check_eq("rst_inst", inst, 8'h00);
                check_eq("rst_inst_valid", inst_valid, 0);
                check_eq("rst_req_valid", imem_req_valid, 0);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_rsp_err", rsp_err, 0);
                post_rst = 0;
            end
            if (inst_valid) begin
                if (exp_q.size() > 0) check_eq("inst_order", inst, exp_q.pop_front());
                else                  check_eq("extra_issue", inst_valid, 0);
                n_issued++;
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
            end else begin
                check_eq("nop_inst", inst, 8'h00);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            check_eq("rsp_err", rsp_err, exp_err);
            if (!busy) check_eq("req_when_idle", imem_req_valid, 0);
            check_eq("credit", (n_hs - n_issued) <= DEPTH, 1);
        end
        rst            = r;
        start          = st;
        prog_len       = pl;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 8'($urandom);
        if (r) begin
            imem_req_ready = 1'b0;
            pend_addr.delete();
            pend_due.delete();
            exp_q.delete();
            exp_err  = 0;
            n_hs     = 0;
            n_issued = 0;
            mon_en   = 1;
            post_rst = 1;
        end else begin
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            if (spur) begin
                imem_rsp_valid = 1'b1;
                exp_err        = 1;
            end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_img[pend_addr.pop_front()];
                void'(pend_due.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                check_eq("req_addr", imem_req_addr, exp_pc);
                exp_pc++;
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (pend_due.size() > 0 && pend_due[$] > due) due = pend_due[$];
                pend_addr.push_back(int'(imem_req_addr));
                pend_due.push_back(due);
                n_hs++;
            end
        end
    endtask

    task automatic start_prog(input logic [7:0] len);
        exp_q.delete();
        for (int i = 0; i < int'(len); i++) exp_q.push_back(mem_img[i]);
        exp_pc    = 0;
        n_done    = 0;
        first_iss = -1;
        last_iss  = -1;
        done_cyc  = -1;
        cycle(1'b1, len, 1'b0, 1'b0);
        start_cyc = cyc;
    endtask

    task automatic run_to_done(input string tag, input int budget, input int restart_at);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            cycle(k == restart_at, 8'd9, 1'b0, 1'b0);
            k++;
        end
        check_eq({tag, "_timeout"}, n_done != 0, 1);
        repeat (3) cycle(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq({tag, "_done_once"}, n_done, 1);
        check_eq({tag, "_all_issued"}, exp_q.size(), 0);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int base;
        int k;
        rst = 1'b1; start = 1'b0; prog_len = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 8'h00;
        exp_err = 0; mon_en = 0; post_rst = 0; n_hs = 0; n_issued = 0; exp_pc = 0;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);

        repeat (2) cycle(1'b0, 8'd0, 1'b1, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);

        mem_img[0] = 8'h41; mem_img[1] = 8'h86; mem_img[2] = 8'hC9;
        start_prog(8'd3);
        run_to_done("basic", 200, -1);
        check_eq("basic_consecutive", last_iss - first_iss, 2);

        lat_min = 5; lat_max = 5;
        start_prog(8'd8);
        run_to_done("credit", 400, -1);

        start_prog(8'd0);
        run_to_done("empty", 20, -1);
        check_eq("empty_latency", done_cyc - start_cyc, 1);

        cycle(1'b0, 8'd0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("spur_err_held", rsp_err, 1);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);

        // Reset while a six-instruction program is in flight.
        lat_min = 1; lat_max = 3;
        start_prog(8'd6);
        base = n_issued;
        k = 0;
        while ((n_issued - base) < 2 && k < 100) begin
            cycle(1'b0, 8'd0, 1'b0, 1'b0);
            k++;
        end
        check_eq("midrst_two_issued", n_issued - base, 2);
        cycle(1'b0, 8'd0, 1'b1, 1'b0);
        cycle(1'b0, 8'd0, 1'b0, 1'b0);
        start_prog(8'd2);
        run_to_done("after_rst", 100, -1);
        check_eq("after_rst_fetches", n_hs, 2);

        lat_min = 2; lat_max = 2;
        start_prog(8'd4);
        run_to_done("busy_start", 200, 2);

        for (int t = 0; t < 6; t++) begin
            lat_min = 1;
            lat_max = $urandom_range(6, 1);
            rdy_pct = $urandom_range(100, 40);
            start_prog(8'($urandom_range(20, 1)));
            run_to_done("rand", 2000, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
